// File: rtl/db_qp_ram_ctrl.sv
// Deblocking QP top-row buffer controller: sweeps the RAM clear at frame start,
// then round-robin arbitrates one read and one write requester onto the single port.
module db_qp_ram_ctrl #(
    parameter int unsigned           WORD_WIDTH = 20,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [WORD_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start_i,
    output logic                  ready_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_ack_o,
    output logic                  rd_valid_o,
    output logic [WORD_WIDTH-1:0] rd_data_o,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    output logic                  wr_ack_o,
    output logic                  ram_cen_o,
    output logic                  ram_oen_o,
    output logic                  ram_wen_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0] ram_data_o,
    input  logic [WORD_WIDTH-1:0] ram_data_i
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clr_cnt;
    logic             last_rd;
    logic             rd_valid_q;
    logic             rd_gnt;
    logic             wr_gnt;

    // Round-robin: on contention grant whichever side did not win last time
    always_comb begin
        rd_gnt = 1'b0;
        wr_gnt = 1'b0;
        if (state == SERVE) begin
            if (rd_req_i && wr_req_i) begin
                rd_gnt = !last_rd;
                wr_gnt = last_rd;
            end else begin
                rd_gnt = rd_req_i;
                wr_gnt = wr_req_i;
            end
        end
    end

    // RAM port mux
    always_comb begin
        ready_o    = (state == SERVE);
        rd_ack_o   = rd_gnt;
        wr_ack_o   = wr_gnt;
        ram_cen_o  = 1'b1;
        ram_wen_o  = 1'b1;
        ram_oen_o  = 1'b1;
        ram_addr_o = '0;
        ram_data_o = '0;
        case (state)
            INIT: begin
                ram_cen_o  = 1'b0;
                ram_wen_o  = 1'b0;
                ram_addr_o = clr_cnt[ADDR_WIDTH-1:0];
                ram_data_o = INIT_VALUE;
            end
            SERVE: begin
                ram_oen_o = 1'b0;
                if (rd_gnt) begin
                    ram_cen_o  = 1'b0;
                    ram_addr_o = rd_addr_i;
                end else if (wr_gnt) begin
                    ram_cen_o  = 1'b0;
                    ram_wen_o  = 1'b0;
                    ram_addr_o = wr_addr_i;
                    ram_data_o = wr_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            last_rd    <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_gnt;
            if (rd_gnt) begin
                last_rd <= 1'b1;
            end else if (wr_gnt) begin
                last_rd <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (frame_start_i) begin
                        state   <= INIT;
                        clr_cnt <= '0;
                    end
                end
                INIT: begin
                    // A new frame start restarts the sweep; this cycle's write still lands
                    if (frame_start_i) begin
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + CNT_W'(1);
                        if (clr_cnt == LAST_ADDR) begin
                            state <= SERVE;
                        end
                    end
                end
                SERVE: begin
                    if (frame_start_i) begin
                        state   <= INIT;
                        clr_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = ram_data_i;

endmodule

// File: tb/tb_db_qp_ram_ctrl.sv
// Bench for db_qp_ram_ctrl: RAM model, reference buffer model with arbitration rules,
// and a read-data scoreboard fed by the model and drained by a monitor.
module tb_db_qp_ram_ctrl;

    localparam int unsigned AW    = 3;
    localparam int unsigned WW    = 20;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [WW-1:0] INIT_VAL = '0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          ready;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ack;
    logic          rd_valid;
    logic [WW-1:0] rd_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [WW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          ram_cen, ram_oen, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_wdata;
    logic [WW-1:0] ram_q;

    always #5 clk = ~clk;

    db_qp_ram_ctrl #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT_VAL)) dut (
        .clk(clk), .rst(rst), .frame_start_i(frame_start), .ready_o(ready),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
        .ram_cen_o(ram_cen), .ram_oen_o(ram_oen), .ram_wen_o(ram_wen),
        .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_data_i(ram_q)
    );

    // Single-port SRAM, 1-cycle registered read
    logic [WW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_cen) begin
            if (!ram_wen) mem[ram_addr] <= ram_wdata;
            else          ram_q <= mem[ram_addr];
        end
    end

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer contents, clear progress, last winner
    int            mode = 0;          // 0 idle, 1 clearing, 2 serving
    int            clear_pos = 0;
    bit            last_was_rd = 1'b1;
    bit            exp_valid = 1'b0;
    logic [WW-1:0] ref_mem [DEPTH];
    logic [WW-1:0] exp_q [$];

    always @(negedge clk) begin
        bit eg_r;
        bit eg_w;
        eg_r = 1'b0;
        eg_w = 1'b0;
        if (rst) begin
            mode = 0; clear_pos = 0; last_was_rd = 1'b1; exp_valid = 1'b0;
            exp_q.delete();
            chk("rst_ready", 32'(ready), 32'd0);
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("rst_acks", 32'({rd_ack, wr_ack}), 32'd0);
            chk("rst_cen_wen_oen", 32'({ram_cen, ram_wen, ram_oen}), 32'h7);
        end else begin
            chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
            chk("ready", 32'(ready), 32'(mode == 2));
            if (mode == 2) begin
                if (rd_req && wr_req) begin
                    eg_r = !last_was_rd;
                    eg_w = last_was_rd;
                end else begin
                    eg_r = rd_req;
                    eg_w = wr_req;
                end
            end
            chk("rd_ack", 32'(rd_ack), 32'(eg_r));
            chk("wr_ack", 32'(wr_ack), 32'(eg_w));
            if (mode == 0) begin
                chk("idle_ram", 32'({ram_cen, ram_wen, ram_oen}), 32'h7);
                chk("idle_addr_data", 32'({ram_addr, ram_wdata}), 32'd0);
            end else if (mode == 1) begin
                chk("clr_cen_wen", 32'({ram_cen, ram_wen}), 32'd0);
                chk("clr_addr", 32'(ram_addr), 32'(clear_pos));
                chk("clr_data", 32'(ram_wdata), 32'(INIT_VAL));
                ref_mem[clear_pos] = INIT_VAL;
            end else begin
                chk("serve_oen", 32'(ram_oen), 32'd0);
                chk("serve_cen", 32'(ram_cen), 32'(!(eg_r || eg_w)));
                chk("serve_wen", 32'(ram_wen), 32'(!eg_w));
                if (eg_r) begin
                    chk("rd_addr", 32'(ram_addr), 32'(rd_addr));
                    exp_q.push_back(ref_mem[rd_addr]);
                    last_was_rd = 1'b1;
                end
                if (eg_w) begin
                    chk("wr_addr", 32'(ram_addr), 32'(wr_addr));
                    chk("wr_data", 32'(ram_wdata), 32'(wr_data));
                    ref_mem[wr_addr] = wr_data;
                    last_was_rd = 1'b0;
                end
            end
            exp_valid = eg_r;
            if (mode == 1) begin
                if (frame_start) clear_pos = 0;
                else begin
                    clear_pos++;
                    if (clear_pos == DEPTH) mode = 2;
                end
            end else if (frame_start) begin
                mode = 1;
                clear_pos = 0;
            end
        end
    end

    // Monitor: every presented read word must match the oldest expected one
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL rd_data_unexpected: got %h expected none at %0t", rd_data, $time);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Advance one cycle; a request that was acked is dropped
    task automatic step();
        logic ra, wa;
        @(negedge clk);
        ra = rd_ack;
        wa = wr_ack;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        if (ra) rd_req = 1'b0;
        if (wa) wr_req = 1'b0;
    endtask

    task automatic wait_reqs_done(input string name);
        for (int i = 0; i < 40; i++) begin
            if (!rd_req && !wr_req) return;
            step();
        end
        vectors++;
        errors++;
        $display("FAIL %s_timeout: got pending requests expected none", name);
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 40; i++) begin
            if (ready) return;
            step();
        end
        vectors++;
        errors++;
        $display("FAIL %s_timeout: got ready 0 expected 1", name);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WW-1:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        wait_reqs_done("write");
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_req = 1'b1; rd_addr = a;
        wait_reqs_done("read");
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        // Clear sweep with a read already pending
        rd_req = 1'b1; rd_addr = 3'd2; frame_start = 1'b1;
        step();
        wait_reqs_done("sweep_read");

        // Write then read the same address back to back
        do_write(3'd3, 20'hABCDE);
        do_read(3'd3);
        step();

        // Continuous contention for 4 cycles
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; wr_req = 1'b1;
            if (i == 0) begin
                rd_addr = 3'($urandom_range(0, 7));
                wr_addr = 3'($urandom_range(0, 7));
                wr_data = 20'($urandom);
            end
            step();
            if (!rd_req) rd_addr = 3'($urandom_range(0, 7));
            if (!wr_req) begin
                wr_addr = 3'($urandom_range(0, 7));
                wr_data = 20'($urandom);
            end
        end
        rd_req = 1'b0; wr_req = 1'b0;
        step();

        // Frame start mid-serve clears previously written data
        do_write(3'd5, 20'h12345);
        frame_start = 1'b1;
        step();
        wait_ready("reclear");
        do_read(3'd5);
        step();

        // Sweep restarted at counter 4
        frame_start = 1'b1;
        step();
        repeat (4) step();
        frame_start = 1'b1;
        step();
        wait_ready("restart");
        step();

        // Reset right after a read ack
        do_read(3'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd6;
        repeat (4) step();
        frame_start = 1'b1;
        step();
        wait_reqs_done("post_rst_read");

        // Randomized traffic with occasional frame starts
        for (int i = 0; i < 600; i++) begin
            if (!rd_req && ($urandom_range(0, 2) == 0)) begin
                rd_req = 1'b1; rd_addr = 3'($urandom_range(0, 7));
            end
            if (!wr_req && ($urandom_range(0, 2) == 0)) begin
                wr_req = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = 20'($urandom);
            end
            if ($urandom_range(0, 59) == 0) frame_start = 1'b1;
            step();
        end
        wait_reqs_done("random_drain");
        repeat (3) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/db_qp_ram_ctrl.md
Name: db_qp_ram_ctrl

Overview:
- Controller in front of the deblocking QP top-row buffer: a single-port, 1-cycle-read SRAM with active-low chip enable (cen), output enable (oen) and write enable (wen).
- Clears the buffer at every frame start.
- Shares the single RAM port between a read requester (deblocking filter fetching qp_top for the current LCU column) and a write requester (LCU-done QP update) using round-robin arbitration.
- Returns read data with fixed 1-cycle latency.

Parameters:
- WORD_WIDTH, 20, RAM word width ([5:0] qp_top, [11:6] qp_top_modified, [19:12] qp_top_flag).
- ADDR_WIDTH, 8, RAM address width; depth = 1<<ADDR_WIDTH.
- INIT_VALUE, 0, word written to every entry during the clear sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- frame_start_i  in  1  one-cycle pulse; starts the clear sweep.
- ready_o  out  1  high when in SERVE (clear finished).
- rd_req_i  in  1  read request; held until acked.
- rd_addr_i  in  ADDR_WIDTH  read address.
- rd_ack_o  out  1  read granted this cycle.
- rd_valid_o  out  1  read data valid (cycle after rd_ack_o).
- rd_data_o  out  WORD_WIDTH  read data.
- wr_req_i  in  1  write request; held until acked.
- wr_addr_i  in  ADDR_WIDTH  write address.
- wr_data_i  in  WORD_WIDTH  write data.
- wr_ack_o  out  1  write granted this cycle.
- ram_cen_o  out  1  RAM chip enable, low active.
- ram_oen_o  out  1  RAM output enable, low active.
- ram_wen_o  out  1  RAM write enable, low active.
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_data_o  out  WORD_WIDTH  RAM write data.
- ram_data_i  in  WORD_WIDTH  RAM read data.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, clear counter=0, rr pointer=READ, rd_valid_o=0.
  - Combinational outputs in IDLE: ready_o=0, rd_ack_o=0, wr_ack_o=0, ram_cen_o=1, ram_wen_o=1, ram_oen_o=1, ram_addr_o=0, ram_data_o=0.
- States and transitions:
  - IDLE: no acks, RAM idle. frame_start_i -> INIT, counter=0.
  - INIT: each cycle drives cen=0, wen=0, addr=counter, data=INIT_VALUE, then counter++.
    - After writing address depth-1 -> SERVE.
    - No acks in INIT; requests stay pending.
    - frame_start_i during INIT restarts the sweep: counter=0 next cycle; the current cycle's write still occurs.
  - SERVE: ready_o=1, ram_oen_o=0. frame_start_i -> INIT, counter=0. Any request present in the same cycle as frame_start_i is still arbitrated and served.
- Arbitration (SERVE, combinational, same cycle as request):
  - Only one requester asserting -> it is granted.
  - Both asserting -> grant the one not granted last. The rr pointer updates on every grant.
- Read grant: rd_ack_o=1, cen=0, wen=1, addr=rd_addr_i.
- Write grant: wr_ack_o=1, cen=0, wen=0, addr=wr_addr_i, data=wr_data_i.
- No grant: cen=1, wen=1.
- Read latency:
  - rd_valid_o is a register set to rd_ack_o, so it is high exactly one cycle after each ack.
  - rd_data_o = ram_data_i (RAM output register). It is defined only while rd_valid_o=1.
  - Back-to-back reads sustain one per cycle.
- Write-then-read of the same address in consecutive cycles returns the new data; no bypass is needed.
- Throughput: at most one RAM access per cycle. Under continuous dual requests each requester gets 50%, strictly alternating.
- A requester must hold its req and addr/data stable until acked; the controller does not latch unacked requests.
- Address wrap: the INIT counter is ADDR_WIDTH+1 bits internally. Terminal detection is at depth-1, so there is no wrap into address 0.
- Reset asserted mid-sweep or mid-read: return to IDLE immediately and drop rd_valid_o. The RAM contents are then undefined until the next sweep.

Test Plan (ADDR_WIDTH=3):
- Reset then frame_start pulse -> 8 consecutive writes (addr 0..7, data 0, cen=wen=0). ready_o rises in the cycle after the addr-7 write. No acks during the sweep even with rd_req_i held high.
- SERVE: write addr 3 = 20'hABCDE, then read addr 3 the next cycle -> rd_ack_o in cycle N, rd_valid_o=1 with rd_data_o=20'hABCDE in cycle N+1.
- rd_req_i and wr_req_i both held for 4 cycles, rr pointer starting at READ -> grants W,R,W,R. Exactly one RAM access per cycle; rd_valid_o follows each R grant by 1 cycle.
- Write 20'h12345 to addr 5, then frame_start mid-SERVE, then wait for ready_o and read addr 5 -> data 0.
- frame_start re-pulsed when counter=4 -> counter restarts at 0. Total sweep covers 0..7 after the restart. ready_o stays low until the restarted sweep completes.
- rst asserted in the cycle after a read ack -> rd_valid_o=0 and ram_cen_o=1 immediately, state IDLE; a read request after rst deasserts is not acked until a sweep completes.
